// File: rtl/player_collision_engine.sv
// player_collision_engine
// Clamps a player bounding box to the visible playfield, then scans a small
// platform table one entry per cycle and reports the OR of all contact codes:
// 11 side, 10 landing on top, 01 bumping from below, 00 none.
// Optional feature macro: COLLISION_HIT_INDEX_EN (reports lowest hitting index).
module player_collision_engine #(
    parameter int NUM_PLAT = 6,
    parameter int COORD_W  = 10,
    parameter int H_MAX    = 1023,
    parameter int V_MAX    = 767,
    localparam int AW      = (NUM_PLAT > 1) ? $clog2(NUM_PLAT) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               plat_we,
    input  logic [AW-1:0]      plat_addr,
    input  logic [COORD_W-1:0] plat_x,
    input  logic [COORD_W-1:0] plat_y,
    input  logic [COORD_W-1:0] plat_len,
    input  logic               start,
    input  logic [COORD_W-1:0] pos_x,
    input  logic [COORD_W-1:0] pos_y,
    input  logic [COORD_W-1:0] obj_w,
    input  logic [COORD_W-1:0] obj_h,
    output logic               busy,
    output logic               done,
    output logic [COORD_W-1:0] x_corr,
    output logic [COORD_W-1:0] y_corr,
    output logic [1:0]         result,
    output logic [AW-1:0]      hit_idx
);

    localparam int CW1 = COORD_W + 1;
    localparam int AW1 = AW + 1;
    localparam logic [CW1-1:0] HMAX_E = CW1'(H_MAX);
    localparam logic [CW1-1:0] VMAX_E = CW1'(V_MAX);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLAMP = 2'd1;
    localparam logic [1:0] S_SCAN  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Pull a coordinate back inside [1, lim - size]; sums are one bit wider so they never wrap.
    function automatic logic [COORD_W-1:0] clamp_axis(
        input logic [COORD_W-1:0] p,
        input logic [COORD_W-1:0] s,
        input logic [CW1-1:0]     lim
    );
        logic [CW1-1:0] sum_v;
        logic [CW1-1:0] diff_v;
        sum_v  = {1'b0, p} + {1'b0, s};
        diff_v = lim - {1'b0, s};
        if (p == {COORD_W{1'b0}}) begin
            clamp_axis = COORD_W'(1);
        end else if (sum_v > lim) begin
            clamp_axis = ({1'b0, s} > lim) ? {COORD_W{1'b0}} : diff_v[COORD_W-1:0];
        end else begin
            clamp_axis = p;
        end
    endfunction

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               r_busy;
    logic               r_done;
    logic [COORD_W-1:0] r_pos_x, r_pos_y, r_obj_w, r_obj_h;
    logic [COORD_W-1:0] r_xc, r_yc;
    logic [1:0]         r_acc;
    logic [AW-1:0]      r_idx;
    logic [COORD_W-1:0] r_x_corr, r_y_corr;
    logic [1:0]         r_result;
    logic [NUM_PLAT-1:0] r_valid;
    logic [COORD_W-1:0] r_plat_x   [NUM_PLAT];
    logic [COORD_W-1:0] r_plat_y   [NUM_PLAT];
    logic [COORD_W-1:0] r_plat_len [NUM_PLAT];

    logic               w_wr_en;
    logic               w_last;
    logic [1:0]         w_code;
    logic [CW1-1:0]     w_x, w_y, w_xw, w_yh, w_px, w_py, w_pe;

    assign w_wr_en = plat_we && !r_busy && ({1'b0, plat_addr} < AW1'(NUM_PLAT));
    assign w_last  = (r_idx == AW'(NUM_PLAT - 1));

    // Next-state decode for the evaluation sequencer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = start ? S_CLAMP : S_IDLE;
            S_CLAMP: w_state_nxt = S_SCAN;
            S_SCAN:  w_state_nxt = w_last ? S_DONE : S_SCAN;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Contact code of the table entry currently addressed by the scan index.
    always_comb begin
        w_x    = {1'b0, r_xc};
        w_y    = {1'b0, r_yc};
        w_xw   = {1'b0, r_xc} + {1'b0, r_obj_w};
        w_yh   = {1'b0, r_yc} + {1'b0, r_obj_h};
        w_px   = {1'b0, r_plat_x[r_idx]};
        w_py   = {1'b0, r_plat_y[r_idx]};
        w_pe   = {1'b0, r_plat_x[r_idx]} + {1'b0, r_plat_len[r_idx]};
        w_code = 2'b00;
        if (!r_valid[r_idx]) begin
            w_code = 2'b00;
        end else if ((w_x == w_pe || w_xw == w_px) && w_yh >= w_py && w_y <= w_py) begin
            w_code = 2'b11;
        end else if (w_yh == w_py && w_xw >= w_px && w_x <= w_pe) begin
            w_code = 2'b10;
        end else if (w_y == w_py && w_xw >= w_px && w_x <= w_pe) begin
            w_code = 2'b01;
        end else begin
            w_code = 2'b00;
        end
    end

    // Platform geometry storage; contents are meaningful only where the valid bit is set.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_plat_x[plat_addr]   <= plat_x;
            r_plat_y[plat_addr]   <= plat_y;
            r_plat_len[plat_addr] <= plat_len;
        end
    end

    // Sequencer, operand capture, clamp/scan datapath, valid bits and held results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pos_x  <= {COORD_W{1'b0}};
            r_pos_y  <= {COORD_W{1'b0}};
            r_obj_w  <= {COORD_W{1'b0}};
            r_obj_h  <= {COORD_W{1'b0}};
            r_xc     <= {COORD_W{1'b0}};
            r_yc     <= {COORD_W{1'b0}};
            r_acc    <= 2'b00;
            r_idx    <= {AW{1'b0}};
            r_x_corr <= {COORD_W{1'b0}};
            r_y_corr <= {COORD_W{1'b0}};
            r_result <= 2'b00;
            r_valid  <= {NUM_PLAT{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= (w_state_nxt == S_DONE);
            if (w_wr_en) begin
                r_valid[plat_addr] <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_pos_x <= pos_x;
                        r_pos_y <= pos_y;
                        r_obj_w <= obj_w;
                        r_obj_h <= obj_h;
                    end
                end
                S_CLAMP: begin
                    r_xc  <= clamp_axis(r_pos_x, r_obj_w, HMAX_E);
                    r_yc  <= clamp_axis(r_pos_y, r_obj_h, VMAX_E);
                    r_acc <= 2'b00;
                    r_idx <= {AW{1'b0}};
                end
                S_SCAN: begin
                    r_acc <= r_acc | w_code;
                    r_idx <= r_idx + AW'(1);
                    if (w_last) begin
                        r_x_corr <= r_xc;
                        r_y_corr <= r_yc;
                        r_result <= r_acc | w_code;
                    end
                end
                S_DONE: begin
                    r_idx <= {AW{1'b0}};
                end
                default: begin
                    r_idx <= {AW{1'b0}};
                end
            endcase
        end
    end

`ifdef COLLISION_HIT_INDEX_EN
    logic          r_hit_found;
    logic [AW-1:0] r_hit_work;
    logic [AW-1:0] r_hit_idx;

    // Remember the first (lowest) entry that produced a nonzero code during the scan.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_found <= 1'b0;
            r_hit_work  <= {AW{1'b0}};
            r_hit_idx   <= {AW{1'b0}};
        end else begin
            case (r_state)
                S_CLAMP: begin
                    r_hit_found <= 1'b0;
                    r_hit_work  <= {AW{1'b0}};
                end
                S_SCAN: begin
                    if (w_code != 2'b00 && !r_hit_found) begin
                        r_hit_found <= 1'b1;
                        r_hit_work  <= r_idx;
                    end
                    if (w_last) begin
                        r_hit_idx <= r_hit_found ? r_hit_work
                                   : ((w_code != 2'b00) ? r_idx : {AW{1'b0}});
                    end
                end
                default: begin
                    r_hit_found <= r_hit_found;
                end
            endcase
        end
    end

    assign hit_idx = r_hit_idx;
`else
    assign hit_idx = {AW{1'b0}};
`endif

    assign busy   = r_busy;
    assign done   = r_done;
    assign x_corr = r_x_corr;
    assign y_corr = r_y_corr;
    assign result = r_result;

endmodule
